fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of `instruction_memory`. It owns the 4-bit program counter that drives the memory's `pc` port and captures the returned 8-bit `out_data` into an instruction register. It presents the captured instruction to the decode stage through a valid/ready handshake, with support for PC redirect (branch/jump), back-pressure and a halt opcode.

---
 rtl/fetch_unit.sv | 108 ++++++++++
 tb/tb_fetch_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC driving instruction_memory, captures the
// returned word and presents it to decode over a valid/ready handshake.
module fetch_unit #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8,
  parameter logic [DATA_W-1:0] HALT_OPCODE = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  output logic [ADDR_W-1:0] pc,
  input  logic [DATA_W-1:0] instr_in,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              busy,
  output logic              halted
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   pc_nxt;
  logic [DATA_W-1:0]   instr_out_nxt;
  logic [ADDR_W-1:0]   instr_pc_nxt;
  logic                vld_nxt;
  logic                slot_free;

  assign slot_free = !instr_valid || instr_ready;
  assign busy      = (state == RUN);
  assign halted    = (state == HALT);

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    instr_out_nxt = instr_out;
    instr_pc_nxt  = instr_pc;
    vld_nxt       = instr_valid;
    unique case (state)
      IDLE: begin
        vld_nxt = 1'b0;
        if (start) begin
          pc_nxt    = start_addr;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (redirect) begin
          // Flush: whatever is presented this cycle is dropped, no capture.
          pc_nxt  = redirect_target;
          vld_nxt = 1'b0;
        end else if (slot_free) begin
          instr_out_nxt = instr_in;
          instr_pc_nxt  = pc;
          vld_nxt       = 1'b1;
          if (instr_in == HALT_OPCODE) begin
            state_nxt = HALT;
          end else begin
            pc_nxt = ADDR_W'(pc + 1'b1);
          end
        end
      end
      HALT: begin
        if (redirect) begin
          pc_nxt    = redirect_target;
          vld_nxt   = 1'b0;
          state_nxt = RUN;
        end else if (start) begin
          pc_nxt    = start_addr;
          vld_nxt   = 1'b0;
          state_nxt = RUN;
        end else if (instr_valid && instr_ready) begin
          vld_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        vld_nxt   = 1'b0;
      end
    endcase
  end

  // Register stage: state, PC and instruction register
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= '0;
      instr_out   <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      instr_out   <= instr_out_nxt;
      instr_pc    <= instr_pc_nxt;
      instr_valid <= vld_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written corner sequences,
// and randomized traffic against a spec-level behavioural model.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst, start, redirect, instr_ready;
  logic [3:0] start_addr, redirect_target, pc, instr_pc;
  logic [7:0] instr_in, instr_out;
  logic       instr_valid, busy, halted;

  logic [7:0] mem [16];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign instr_in = mem[pc];

  fetch_unit #(.ADDR_W(4), .DATA_W(8), .HALT_OPCODE(8'hFF)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .pc(pc),
    .instr_in(instr_in), .instr_out(instr_out), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .redirect(redirect),
    .redirect_target(redirect_target), .busy(busy), .halted(halted)
  );

  typedef struct {
    logic       rst, start, redirect, ready;
    logic [3:0] sa, rt;
    logic [3:0] e_pc;
    logic       e_vld;
    logic [7:0] e_out;
    logic [3:0] e_ipc;
    logic       e_busy, e_halted;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic [3:0] sa,
                       input logic rd, input logic [3:0] rt, input logic rdy);
    rst = r; start = s; start_addr = sa; redirect = rd; redirect_target = rt; instr_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_pc, input logic e_vld,
                         input logic [7:0] e_out, input logic [3:0] e_ipc,
                         input logic e_busy, input logic e_halted);
    chk({tag, ".pc"}, 32'(pc), 32'(e_pc));
    chk({tag, ".valid"}, 32'(instr_valid), 32'(e_vld));
    chk({tag, ".out"}, 32'(instr_out), 32'(e_out));
    chk({tag, ".ipc"}, 32'(instr_pc), 32'(e_ipc));
    chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
    chk({tag, ".halted"}, 32'(halted), 32'(e_halted));
  endtask

  // Behavioural model: mode 0 idle, 1 running, 2 halted
  int         m_mode;
  logic [3:0] m_pc, m_ipc;
  logic [7:0] m_out;
  logic       m_vld;

  task automatic model_step(input logic r, input logic s, input logic [3:0] sa,
                            input logic rd, input logic [3:0] rt, input logic rdy);
    logic [7:0] word;
    word = mem[m_pc];
    if (r) begin
      m_mode = 0; m_pc = 0; m_ipc = 0; m_out = 0; m_vld = 0;
    end else if (m_mode != 0 && rd) begin
      m_pc = rt; m_vld = 0; m_mode = 1;
    end else if (m_mode != 1 && s) begin
      m_pc = sa; m_vld = 0; m_mode = 1;
    end else if (m_mode == 1 && (!m_vld || rdy)) begin
      m_out = word; m_ipc = m_pc; m_vld = 1;
      if (word == 8'hFF) m_mode = 2;
      else m_pc = (m_pc + 4'd1) % 16;
    end else if (m_mode == 2 && m_vld && rdy) begin
      m_vld = 0;
    end
  endtask

  vec_t tbl [17];

  initial begin
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);

    //           rst st rd rdy sa  rt    pc  v  out   ipc b  h
    tbl[0]  = '{1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 8'h00, 4'h0, 0, 0};
    tbl[1]  = '{0, 1, 0, 1, 4'h0, 4'h0, 4'h0, 0, 8'h00, 4'h0, 1, 0};
    tbl[2]  = '{0, 0, 0, 1, 4'h0, 4'h0, 4'h1, 1, 8'h00, 4'h0, 1, 0};
    tbl[3]  = '{0, 0, 0, 1, 4'h0, 4'h0, 4'h2, 1, 8'h01, 4'h1, 1, 0};
    tbl[4]  = '{0, 0, 0, 1, 4'h0, 4'h0, 4'h3, 1, 8'h02, 4'h2, 1, 0};
    tbl[5]  = '{0, 0, 1, 1, 4'h0, 4'h9, 4'h9, 0, 8'h02, 4'h2, 1, 0};
    tbl[6]  = '{0, 0, 0, 1, 4'h0, 4'h0, 4'hA, 1, 8'h09, 4'h9, 1, 0};
    tbl[7]  = '{0, 0, 0, 0, 4'h0, 4'h0, 4'hA, 1, 8'h09, 4'h9, 1, 0};
    tbl[8]  = '{0, 0, 0, 0, 4'h0, 4'h0, 4'hA, 1, 8'h09, 4'h9, 1, 0};
    tbl[9]  = '{0, 0, 0, 1, 4'h0, 4'h0, 4'hB, 1, 8'h0A, 4'hA, 1, 0};
    tbl[10] = '{1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 8'h00, 4'h0, 0, 0};
    tbl[11] = '{0, 0, 1, 1, 4'h0, 4'h5, 4'h0, 0, 8'h00, 4'h0, 0, 0};
    tbl[12] = '{0, 1, 0, 1, 4'hE, 4'h0, 4'hE, 0, 8'h00, 4'h0, 1, 0};
    tbl[13] = '{0, 0, 0, 1, 4'h0, 4'h0, 4'hF, 1, 8'h0E, 4'hE, 1, 0};
    tbl[14] = '{0, 0, 0, 1, 4'h0, 4'h0, 4'h0, 1, 8'h0F, 4'hF, 1, 0};
    tbl[15] = '{0, 0, 0, 1, 4'h0, 4'h0, 4'h1, 1, 8'h00, 4'h0, 1, 0};
    tbl[16] = '{0, 0, 0, 1, 4'h0, 4'h0, 4'h2, 1, 8'h01, 4'h1, 1, 0};

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].rst, tbl[i].start, tbl[i].sa, tbl[i].redirect, tbl[i].rt, tbl[i].ready);
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_vld, tbl[i].e_out,
              tbl[i].e_ipc, tbl[i].e_busy, tbl[i].e_halted);
    end

    // Back-pressure while 03 is presented
    drive(1, 0, 0, 0, 0, 1); tick();
    drive(0, 1, 0, 0, 0, 1); tick();
    drive(0, 0, 0, 0, 0, 1);
    repeat (4) tick();
    chk_all("bp_pre", 4'h4, 1, 8'h03, 4'h3, 1, 0);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all($sformatf("bp_stall%0d", i), 4'h4, 1, 8'h03, 4'h3, 1, 0);
    end
    drive(0, 0, 0, 0, 0, 1); tick();
    chk_all("bp_release", 4'h5, 1, 8'h04, 4'h4, 1, 0);

    // Reset during a stall drops the pending instruction
    drive(0, 0, 0, 0, 0, 0); tick();
    chk_all("rs_stall", 4'h5, 1, 8'h04, 4'h4, 1, 0);
    drive(1, 0, 0, 0, 0, 0); tick();
    chk_all("rs_reset", 4'h0, 0, 8'h00, 4'h0, 0, 0);
    drive(0, 0, 0, 0, 0, 1); tick();
    chk_all("rs_after", 4'h0, 0, 8'h00, 4'h0, 0, 0);

    // Halt opcode at address 5
    mem[5] = 8'hFF;
    drive(0, 1, 4'h3, 0, 0, 1); tick();
    chk_all("h_start", 4'h3, 0, 8'h00, 4'h0, 1, 0);
    drive(0, 0, 0, 0, 0, 1); tick();
    chk_all("h_03", 4'h4, 1, 8'h03, 4'h3, 1, 0);
    tick();
    chk_all("h_04", 4'h5, 1, 8'h04, 4'h4, 1, 0);
    tick();
    chk_all("h_ff", 4'h5, 1, 8'hFF, 4'h5, 0, 1);
    tick();
    chk_all("h_accepted", 4'h5, 0, 8'hFF, 4'h5, 0, 1);
    tick();
    chk_all("h_hold", 4'h5, 0, 8'hFF, 4'h5, 0, 1);
    drive(0, 1, 4'h0, 0, 0, 1); tick();
    chk_all("h_restart", 4'h0, 0, 8'hFF, 4'h5, 1, 0);
    drive(0, 0, 0, 0, 0, 1); tick();
    chk_all("h_fetch00", 4'h1, 1, 8'h00, 4'h0, 1, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 16; i++) mem[i] = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
    drive(1, 0, 0, 0, 0, 0);
    model_step(1, 0, 0, 0, 0, 0);
    tick();
    for (int c = 0; c < 600; c++) begin
      logic r, s, rd, rdy;
      logic [3:0] sa, rt;
      r   = ($urandom_range(0, 49) == 0);
      s   = ($urandom_range(0, 7) == 0);
      rd  = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      sa  = 4'($urandom);
      rt  = 4'($urandom);
      if (c % 100 == 50) mem[$urandom_range(0, 15)] = 8'($urandom);
      drive(r, s, sa, rd, rt, rdy);
      model_step(r, s, sa, rd, rt, rdy);
      tick();
      chk("rnd.pc", 32'(pc), 32'(m_pc));
      chk("rnd.valid", 32'(instr_valid), 32'(m_vld));
      chk("rnd.busy", 32'(busy), 32'(m_mode == 1));
      chk("rnd.halted", 32'(halted), 32'(m_mode == 2));
      if (m_vld) begin
        chk("rnd.out", 32'(instr_out), 32'(m_out));
        chk("rnd.ipc", 32'(instr_pc), 32'(m_ipc));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
